rv16_if_stage: RTL and testbench
================================

RV16_IF_STAGE -- requirements
Module: rv16_if_stage

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000, meaning the first fetch address after reset.
REQ-002 SHALL have port clk, input, 1, system clock; all state changes on rising edge.
REQ-003 SHALL have port rst_n, input, 1, reset: synchronous, active-low.
REQ-004 SHALL have o_imem_req, output, 1, instruction memory request.
REQ-005 SHALL have o_imem_addr, output, 32, request word address.
REQ-006 SHALL have i_imem_gnt, input, 1, request accepted this cycle.
REQ-007 SHALL have i_imem_rvalid and i_imem_rdata, inputs, 1 and 32, in-order response, earliest one cycle after grant.
REQ-008 SHALL have o_fetch_valid, o_fetch_data and o_pc, outputs, 1/32/32, instruction to the decode/execute stage.
REQ-009 SHALL have i_stall, input, 1, downstream cannot consume.
REQ-010 SHALL have i_flush, input, 1, discard buffered and in-flight instructions.
REQ-011 SHALL have i_pc_update and i_next_pc, inputs, 1 and 32, branch/jump redirect.
REQ-012 SHALL have o_misalign, output, 1, misaligned redirect flag (see Configuration).

Function
REQ-013 SHALL hold a 2-entry instruction FIFO of {pc, data}; o_fetch_valid = FIFO non-empty; o_fetch_data/o_pc = head entry.
REQ-014 Consume SHALL occur when o_fetch_valid && !i_stall; the head pops that edge.
REQ-015 SHALL assert o_imem_req when fifo_count + outstanding < 2 and no redirect/flush is active this cycle.
REQ-016 o_imem_addr SHALL equal fetch PC; fetch PC +4 on req && gnt; address stable while req && !gnt.
REQ-017 Outstanding count (0..2) SHALL increment on req && gnt and decrement on rvalid, both in the same cycle = no change.
REQ-018 Each granted request SHALL push its PC into a 2-entry in-flight PC queue, popped on rvalid.
REQ-019 On rvalid with discard count 0, SHALL push {queued pc, rdata} into the FIFO; simultaneous push and pop both take effect.
REQ-020 SHALL keep cons_pc = PC of next instruction delivered downstream; +4 on each consume.
REQ-021 On i_pc_update: fetch PC <= i_next_pc with [1:0] forced 00, cons_pc <= same, FIFO cleared, discard count <= outstanding after this cycle's gnt/rvalid.
REQ-022 On i_flush without i_pc_update: identical to REQ-021 but target = cons_pc.
REQ-023 i_pc_update SHALL take priority over i_flush and i_stall; i_stall SHALL NOT block redirect.
REQ-024 rvalid while discard count > 0 (or in the redirect cycle) SHALL be dropped and decrement discard count.
REQ-025 o_fetch_valid SHALL be 0 the cycle after a redirect/flush; first post-redirect request issued that cycle.
REQ-026 Fetch PC SHALL wrap 32'hFFFF_FFFC -> 32'h0000_0000 without flag.

Reset
REQ-027 While rst_n=0 at a clock edge: o_imem_req=0, o_fetch_valid=0, o_fetch_data=0, o_pc=RESET_PC, o_imem_addr=RESET_PC, o_misalign=0, all counts 0, FIFOs empty.
REQ-028 Reset mid-operation SHALL abandon in-flight requests; responses arriving after reset release with outstanding=0 SHALL be ignored.
REQ-029 First o_imem_req SHALL assert the first cycle after rst_n rises.

Configuration
REQ-030 Macro RV16_IF_ALIGN_CHK_EN: defined -> o_misalign pulses high one cycle after a redirect with i_next_pc[1:0] != 0; undefined -> o_misalign tied 0. Target alignment per REQ-021 in both cases.

Verification
REQ-031 Reset release, gnt=1, rvalid one cycle later with data 32'h02208133 -> o_fetch_valid with o_pc=0, o_fetch_data=32'h02208133; next addresses 4, 8.
REQ-032 i_stall held high with FIFO full -> o_imem_req=0, outstanding=0, head stays pc=0 until stall drops.
REQ-033 i_pc_update with i_next_pc=32'h100 while 2 requests outstanding -> both responses dropped; next valid o_pc=32'h100.
REQ-034 Consume pc=8, then i_flush -> refetch starts at 32'hC; no instruction delivered twice or skipped.
REQ-035 With RV16_IF_ALIGN_CHK_EN, redirect to 32'h102 -> o_misalign one-cycle pulse, o_imem_addr=32'h100; without macro o_misalign stays 0.
REQ-036 gnt held 0 for 5 cycles -> o_imem_addr constant, o_fetch_valid=0; gnt rises -> normal fetch resumes.

Source files
------------

// File: rtl/rv16_if_stage.sv
// ---------------------------------------------------------------------------
// rv16_if_stage -- instruction fetch stage
//
// Purpose
//   Issues word fetches to an instruction memory with a req/gnt handshake,
//   collects the in-order responses and holds them in a 2-entry {pc, data}
//   FIFO for the decode/execute stage. A branch/jump redirect (i_pc_update)
//   or a flush (i_flush) empties the FIFO and drops every response that is
//   still in flight. At most two instructions are either buffered or in
//   flight at any time.
//
// Configuration
//   RV16_IF_ALIGN_CHK_EN : when defined, o_misalign pulses for one cycle
//                          after a redirect whose target has bits [1:0] != 0.
//                          When undefined, o_misalign is tied low. The
//                          redirect target is word-aligned in both builds.
//
// Parameters
//   RESET_PC       first fetch address after reset
//
// Ports
//   clk            system clock, rising edge
//   rst_n          synchronous active-low reset
//   o_imem_req     fetch request
//   o_imem_addr    fetch word address (current fetch PC)
//   i_imem_gnt     request accepted this cycle
//   i_imem_rvalid  response valid (in order, at least one cycle after gnt)
//   i_imem_rdata   response data
//   o_fetch_valid  instruction available at the FIFO head
//   o_fetch_data   head instruction word
//   o_pc           head instruction PC
//   i_stall        downstream cannot consume this cycle
//   i_flush        refetch from the next undelivered PC
//   i_pc_update    redirect to i_next_pc (wins over i_flush and i_stall)
//   i_next_pc      redirect target
//   o_misalign     misaligned redirect flag
// ---------------------------------------------------------------------------
module rv16_if_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        o_imem_req,
  output logic [31:0] o_imem_addr,
  input  logic        i_imem_gnt,
  input  logic        i_imem_rvalid,
  input  logic [31:0] i_imem_rdata,
  output logic        o_fetch_valid,
  output logic [31:0] o_fetch_data,
  output logic [31:0] o_pc,
  input  logic        i_stall,
  input  logic        i_flush,
  input  logic        i_pc_update,
  input  logic [31:0] i_next_pc,
  output logic        o_misalign
);

  // Registered state and next-state values
  logic        started_q;
  logic [31:0] fetch_pc_q,  fetch_pc_d;
  logic [31:0] cons_pc_q,   cons_pc_d;
  logic [1:0]  fifo_cnt_q,  fifo_cnt_d;
  logic [31:0] f0_pc_q,     f0_pc_d;
  logic [31:0] f0_data_q,   f0_data_d;
  logic [31:0] f1_pc_q,     f1_pc_d;
  logic [31:0] f1_data_q,   f1_data_d;
  logic [1:0]  outst_q,     outst_d;
  logic [31:0] iq0_pc_q,    iq0_pc_d;
  logic [31:0] iq1_pc_q,    iq1_pc_d;
  logic [1:0]  discard_q,   discard_d;
  logic        misalign_q,  misalign_d;

  // Combinational control
  logic        redirect_s;
  logic [2:0]  occupancy_s;
  logic        req_s;
  logic        grant_s;
  logic        rsp_s;
  logic        consume_s;
  logic        keep_s;
  logic [31:0] cons_next_s;
  logic [31:0] target_s;
  logic [1:0]  fifo_slot_s;
  logic [1:0]  iq_slot_s;

  assign redirect_s  = i_pc_update | i_flush;
  assign occupancy_s = {1'b0, fifo_cnt_q} + {1'b0, outst_q};
  // started_q keeps req low during reset and for the cycle rst_n is released
  assign req_s       = started_q & ~redirect_s & (occupancy_s < 3'd2);
  assign grant_s     = req_s & i_imem_gnt;
  // A response with nothing outstanding (e.g. left over from before a reset)
  // is not ours and is ignored entirely.
  assign rsp_s       = i_imem_rvalid & (outst_q != 2'd0);
  assign consume_s   = (fifo_cnt_q != 2'd0) & ~i_stall;
  assign keep_s      = rsp_s & ~redirect_s & (discard_q == 2'd0);

  // A consume in the flush cycle still counts: the flush restarts after it.
  assign cons_next_s = consume_s ? (cons_pc_q + 32'd4) : cons_pc_q;
  assign target_s    = i_pc_update ? {i_next_pc[31:2], 2'b00}
                                   : {cons_next_s[31:2], 2'b00};

  // Slot that a new entry lands in once this cycle's pop has shifted the queue
  assign fifo_slot_s = fifo_cnt_q - {1'b0, consume_s};
  assign iq_slot_s   = outst_q - {1'b0, rsp_s};

  assign outst_d     = outst_q + {1'b0, grant_s} - {1'b0, rsp_s};

  // Fetch PC advances on every accepted request and wraps naturally at 2^32
  assign fetch_pc_d  = redirect_s ? target_s
                     : (grant_s ? (fetch_pc_q + 32'd4) : fetch_pc_q);
  assign cons_pc_d   = redirect_s ? target_s : cons_next_s;

  // In-flight PC queue: shift on response, append on grant
  assign iq0_pc_d    = (grant_s && (iq_slot_s == 2'd0)) ? fetch_pc_q
                     : (rsp_s ? iq1_pc_q : iq0_pc_q);
  assign iq1_pc_d    = (grant_s && (iq_slot_s == 2'd1)) ? fetch_pc_q : iq1_pc_q;

  // Instruction FIFO: shift on consume, append kept responses
  assign f0_pc_d     = (keep_s && (fifo_slot_s == 2'd0)) ? iq0_pc_q
                     : (consume_s ? f1_pc_q : f0_pc_q);
  assign f0_data_d   = (keep_s && (fifo_slot_s == 2'd0)) ? i_imem_rdata
                     : (consume_s ? f1_data_q : f0_data_q);
  assign f1_pc_d     = (keep_s && (fifo_slot_s == 2'd1)) ? iq0_pc_q : f1_pc_q;
  assign f1_data_d   = (keep_s && (fifo_slot_s == 2'd1)) ? i_imem_rdata : f1_data_q;
  assign fifo_cnt_d  = redirect_s ? 2'd0
                     : (fifo_cnt_q - {1'b0, consume_s} + {1'b0, keep_s});

  // Everything still in flight after a redirect belongs to the old path
  assign discard_d   = redirect_s ? outst_d
                     : ((rsp_s && (discard_q != 2'd0)) ? (discard_q - 2'd1)
                                                        : discard_q);

`ifdef RV16_IF_ALIGN_CHK_EN
  assign misalign_d  = i_pc_update & (i_next_pc[1:0] != 2'b00);
`else
  logic unused_align_s;
  assign unused_align_s = ^i_next_pc[1:0];
  assign misalign_d  = 1'b0;
`endif

  // State registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      started_q  <= 1'b0;
      fetch_pc_q <= RESET_PC;
      cons_pc_q  <= RESET_PC;
      fifo_cnt_q <= 2'd0;
      f0_pc_q    <= RESET_PC;
      f0_data_q  <= 32'h0000_0000;
      f1_pc_q    <= RESET_PC;
      f1_data_q  <= 32'h0000_0000;
      outst_q    <= 2'd0;
      iq0_pc_q   <= 32'h0000_0000;
      iq1_pc_q   <= 32'h0000_0000;
      discard_q  <= 2'd0;
      misalign_q <= 1'b0;
    end else begin
      started_q  <= 1'b1;
      fetch_pc_q <= fetch_pc_d;
      cons_pc_q  <= cons_pc_d;
      fifo_cnt_q <= fifo_cnt_d;
      f0_pc_q    <= f0_pc_d;
      f0_data_q  <= f0_data_d;
      f1_pc_q    <= f1_pc_d;
      f1_data_q  <= f1_data_d;
      outst_q    <= outst_d;
      iq0_pc_q   <= iq0_pc_d;
      iq1_pc_q   <= iq1_pc_d;
      discard_q  <= discard_d;
      misalign_q <= misalign_d;
    end
  end

  assign o_imem_req    = req_s;
  assign o_imem_addr   = fetch_pc_q;
  assign o_fetch_valid = (fifo_cnt_q != 2'd0);
  assign o_fetch_data  = f0_data_q;
  // With nothing buffered, report the PC that will be delivered next
  assign o_pc          = o_fetch_valid ? f0_pc_q : cons_pc_q;
  assign o_misalign    = misalign_q;

endmodule

// File: tb/tb_rv16_if_stage.sv
// ---------------------------------------------------------------------------
// tb_rv16_if_stage -- self-checking bench for rv16_if_stage
//
// A queue-based reference model tracks the buffered instructions, the
// in-flight requests (each tagged "drop" once a redirect overtakes it), the
// fetch PC and the next PC owed downstream. Directed scenarios come first,
// then randomized traffic with occasional mid-run resets.
// ---------------------------------------------------------------------------
module tb_rv16_if_stage;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;
`ifdef RV16_IF_ALIGN_CHK_EN
  localparam logic [31:0] EXP_MIS_PULSE = 32'd1;
`else
  localparam logic [31:0] EXP_MIS_PULSE = 32'd0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic        o_imem_req;
  logic [31:0] o_imem_addr;
  logic        i_imem_gnt;
  logic        i_imem_rvalid;
  logic [31:0] i_imem_rdata;
  logic        o_fetch_valid;
  logic [31:0] o_fetch_data;
  logic [31:0] o_pc;
  logic        i_stall;
  logic        i_flush;
  logic        i_pc_update;
  logic [31:0] i_next_pc;
  logic        o_misalign;

  always #5 clk = ~clk;

  rv16_if_stage #(.RESET_PC(RESET_PC)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .o_imem_req   (o_imem_req),
    .o_imem_addr  (o_imem_addr),
    .i_imem_gnt   (i_imem_gnt),
    .i_imem_rvalid(i_imem_rvalid),
    .i_imem_rdata (i_imem_rdata),
    .o_fetch_valid(o_fetch_valid),
    .o_fetch_data (o_fetch_data),
    .o_pc         (o_pc),
    .i_stall      (i_stall),
    .i_flush      (i_flush),
    .i_pc_update  (i_pc_update),
    .i_next_pc    (i_next_pc),
    .o_misalign   (o_misalign)
  );

  int n_vec = 0;
  int n_err = 0;

  // Reference model state
  bit          m_started;
  logic [31:0] m_fetch;
  logic [31:0] m_cons;
  logic        m_mis;
  logic [31:0] b_pc[$];
  logic [31:0] b_data[$];
  logic [31:0] q_pc[$];
  bit          q_drop[$];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_started = 1'b0;
    m_fetch   = RESET_PC;
    m_cons    = RESET_PC;
    m_mis     = 1'b0;
    b_pc.delete();
    b_data.delete();
    q_pc.delete();
    q_drop.delete();
  endtask

  task automatic do_reset(input int n);
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      rst_n         = 1'b0;
      i_imem_gnt    = 1'($urandom);
      i_imem_rvalid = 1'($urandom);
      i_imem_rdata  = $urandom;
      i_stall       = 1'($urandom);
      i_flush       = 1'($urandom);
      i_pc_update   = 1'($urandom);
      i_next_pc     = $urandom;
      @(posedge clk);
      #1;
      chk("rst_req",   32'(o_imem_req), 32'd0);
      chk("rst_valid", 32'(o_fetch_valid), 32'd0);
      chk("rst_data",  o_fetch_data, 32'd0);
      chk("rst_pc",    o_pc, RESET_PC);
      chk("rst_addr",  o_imem_addr, RESET_PC);
      chk("rst_mis",   32'(o_misalign), 32'd0);
    end
    model_reset();
  endtask

  // One clock cycle: drive, check outputs against the model, advance the model
  task automatic step(input logic stall, input logic flush, input logic upd,
                      input logic [31:0] npc, input logic gnt, input logic rv,
                      input logic [31:0] rdata);
    logic        exp_req;
    logic        cons;
    logic        rsp;
    logic        rdrop;
    logic [31:0] rpc;
    logic [31:0] tgt;
    @(negedge clk);
    rst_n         = 1'b1;
    i_stall       = stall;
    i_flush       = flush;
    i_pc_update   = upd;
    i_next_pc     = npc;
    i_imem_gnt    = gnt;
    i_imem_rvalid = rv;
    i_imem_rdata  = rdata;
    #1;
    exp_req = m_started && !upd && !flush && ((b_pc.size() + q_pc.size()) < 2);
    chk("req",   32'(o_imem_req), 32'(exp_req));
    chk("valid", 32'(o_fetch_valid), 32'(b_pc.size() > 0));
    chk("addr",  o_imem_addr, m_fetch);
    chk("mis",   32'(o_misalign), 32'(m_mis));
    if (b_pc.size() > 0) begin
      chk("head_pc",   o_pc, b_pc[0]);
      chk("head_data", o_fetch_data, b_data[0]);
      chk("order",     b_pc[0], m_cons);
    end
    @(posedge clk);
    cons  = (b_pc.size() > 0) && !stall;
    rsp   = rv && (q_pc.size() > 0);
    rpc   = 32'd0;
    rdrop = 1'b1;
    if (rsp) begin
      rpc   = q_pc.pop_front();
      rdrop = q_drop.pop_front();
    end
    if (upd || flush) begin
      tgt = upd ? npc : (m_cons + (cons ? 32'd4 : 32'd0));
      tgt[1:0] = 2'b00;
      b_pc.delete();
      b_data.delete();
      foreach (q_drop[i]) q_drop[i] = 1'b1;
      m_fetch = tgt;
      m_cons  = tgt;
    end else begin
      if (cons) begin
        void'(b_pc.pop_front());
        void'(b_data.pop_front());
        m_cons = m_cons + 32'd4;
      end
      if (rsp && !rdrop) begin
        b_pc.push_back(rpc);
        b_data.push_back(rdata);
      end
      if (exp_req && gnt) begin
        q_pc.push_back(m_fetch);
        q_drop.push_back(1'b0);
        m_fetch = m_fetch + 32'd4;
      end
    end
`ifdef RV16_IF_ALIGN_CHK_EN
    m_mis = upd && (npc[1:0] != 2'b00);
`else
    m_mis = 1'b0;
`endif
    m_started = 1'b1;
  endtask

  initial begin
    logic rv;
    logic [31:0] npc;
    model_reset();
    do_reset(3);

    // First fetch after reset
    step(1'b0, 1'b0, 1'b0, 32'd0, 1'b1, 1'b0, 32'd0);
    step(1'b0, 1'b0, 1'b0, 32'd0, 1'b1, 1'b0, 32'd0);
    #1 chk("r031_addr4", o_imem_addr, 32'h4);
    step(1'b1, 1'b0, 1'b0, 32'd0, 1'b1, 1'b1, 32'h0220_8133);
    #1;
    chk("r031_valid", 32'(o_fetch_valid), 32'd1);
    chk("r031_pc",    o_pc, 32'h0);
    chk("r031_data",  o_fetch_data, 32'h0220_8133);
    chk("r031_addr8", o_imem_addr, 32'h8);

    // Stall with the FIFO full
    step(1'b1, 1'b0, 1'b0, 32'd0, 1'b1, 1'b1, $urandom);
    for (int k = 0; k < 4; k++) begin
      #1;
      chk("r032_req", 32'(o_imem_req), 32'd0);
      chk("r032_pc",  o_pc, 32'h0);
      step(1'b1, 1'b0, 1'b0, 32'd0, 1'b1, 1'b0, 32'd0);
    end
    step(1'b0, 1'b0, 1'b0, 32'd0, 1'b0, 1'b0, 32'd0);
    #1 chk("r032_next_pc", o_pc, 32'h4);
    step(1'b0, 1'b0, 1'b0, 32'd0, 1'b0, 1'b0, 32'd0);

    // Redirect with two requests outstanding
    step(1'b1, 1'b0, 1'b0, 32'd0, 1'b1, 1'b0, 32'd0);
    step(1'b1, 1'b0, 1'b0, 32'd0, 1'b1, 1'b0, 32'd0);
    step(1'b0, 1'b0, 1'b1, 32'h100, 1'b0, 1'b0, 32'd0);
    #1;
    chk("r033_valid0", 32'(o_fetch_valid), 32'd0);
    chk("r033_addr",   o_imem_addr, 32'h100);
    step(1'b0, 1'b0, 1'b0, 32'd0, 1'b1, 1'b1, $urandom);
    step(1'b0, 1'b0, 1'b0, 32'd0, 1'b1, 1'b1, $urandom);
    step(1'b1, 1'b0, 1'b0, 32'd0, 1'b0, 1'b1, $urandom);
    #1;
    chk("r033_valid1", 32'(o_fetch_valid), 32'd1);
    chk("r033_pc",     o_pc, 32'h100);

    // Consume pc 8, then flush
    step(1'b1, 1'b0, 1'b1, 32'h8, 1'b0, 1'b0, 32'd0);
    step(1'b1, 1'b0, 1'b0, 32'd0, 1'b1, 1'b0, 32'd0);
    step(1'b1, 1'b0, 1'b0, 32'd0, 1'b1, 1'b1, $urandom);
    step(1'b0, 1'b0, 1'b0, 32'd0, 1'b0, 1'b0, 32'd0);
    step(1'b0, 1'b1, 1'b0, 32'd0, 1'b0, 1'b0, 32'd0);
    #1;
    chk("r034_addr",  o_imem_addr, 32'hC);
    chk("r034_valid", 32'(o_fetch_valid), 32'd0);
    step(1'b0, 1'b0, 1'b0, 32'd0, 1'b1, 1'b1, $urandom);
    step(1'b1, 1'b0, 1'b0, 32'd0, 1'b0, 1'b1, $urandom);
    #1 chk("r034_pc", o_pc, 32'hC);

    // Misaligned redirect
    step(1'b0, 1'b0, 1'b1, 32'h102, 1'b0, 1'b0, 32'd0);
    #1;
    chk("r035_addr", o_imem_addr, 32'h100);
    chk("r035_mis",  32'(o_misalign), EXP_MIS_PULSE);
    step(1'b0, 1'b0, 1'b0, 32'd0, 1'b0, 1'b0, 32'd0);
    #1 chk("r035_mis_end", 32'(o_misalign), 32'd0);

    // Grant withheld
    for (int k = 0; k < 5; k++) begin
      step(1'b0, 1'b0, 1'b0, 32'd0, 1'b0, 1'b0, 32'd0);
      #1;
      chk("r036_addr",  o_imem_addr, 32'h100);
      chk("r036_valid", 32'(o_fetch_valid), 32'd0);
    end
    step(1'b0, 1'b0, 1'b0, 32'd0, 1'b1, 1'b0, 32'd0);
    step(1'b1, 1'b0, 1'b0, 32'd0, 1'b1, 1'b1, $urandom);
    #1;
    chk("r036_pc",   o_pc, 32'h100);
    chk("r036_addr", o_imem_addr, 32'h108);

    // Randomized traffic
    for (int c = 0; c < 4000; c++) begin
      if ($urandom_range(0, 299) == 0) begin
        do_reset(1 + $urandom_range(0, 2));
      end else begin
        rv  = (q_pc.size() > 0) ? 1'($urandom) : ($urandom_range(0, 15) == 0);
        npc = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 + 32'($urandom_range(0, 15)))
                                          : $urandom;
        step($urandom_range(0, 9) < 3, $urandom_range(0, 19) == 0,
             $urandom_range(0, 19) == 0, npc, $urandom_range(0, 9) < 6,
             rv, $urandom);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
